fp16_normalize_round: RTL

- Post-add normalization and rounding stage of the half-precision FPU; sits directly downstream of the significand adder.
- Takes an unnormalized 16-bit magnitude plus exponent and sign.
- Counts leading zeros with lzd_16, shifts left, adjusts the exponent, rounds to nearest-even and packs an IEEE binary16 result.
- Two-stage pipeline with valid/ready handshake on both sides.

---
 rtl/fpu_pkg.sv | 25 ++
 rtl/lzd_16.sv | 21 ++
 rtl/fp16_normalize_round.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared binary16 constants and pipeline types for the half-precision FPU
package fpu_pkg;

    localparam int EXP_W   = 5;
    localparam int FRAC_W  = 10;
    localparam int BIAS    = 15;
    localparam int EXP_MAX = 31;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp16_t;

    // Stage-1 register contents: mant is normalized with the hidden one at
    // bit 15 (or positioned for a subnormal when exp_n == 0).
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp_n;
        logic [15:0]       mant;
        logic              zero;
        logic              ovf;
    } norm_stage_t;

endpackage

// File: rtl/lzd_16.sv
// rtl/lzd_16.sv - leading zero counter for a 16-bit magnitude
//
// Ports:
//   mant  : 16-bit magnitude
//   count : number of leading zeros, 0..16 (16 when mant is zero)
module lzd_16 (
    input  logic [15:0] mant,
    output logic [4:0]  count
);

    // Scanning upward lets the highest set bit win the last assignment.
    always_comb begin
        count = 5'd16;
        for (int i = 0; i < 16; i++) begin
            if (mant[i]) begin
                count = 5'(15 - i);
            end
        end
    end

endmodule

// File: rtl/fp16_normalize_round.sv
// rtl/fp16_normalize_round.sv - two-stage normalize / round-to-nearest-even / pack stage
//
// Macro FP_NORM_DENORM_EN: defined gives gradual underflow (subnormal results);
// undefined flushes any nonzero result whose rounded exponent is 0 to signed zero.
//
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   in_valid / in_ready       : upstream handshake
//   in_sign, in_exp, in_mant  : unnormalized operand (in_exp refers to mant bit 14)
//   in_tag                    : opaque sideband tag
//   out_valid / out_ready     : downstream handshake
//   out_result                : packed binary16 result
//   out_tag                   : tag travelling with the result
//   out_inexact, out_overflow, out_underflow : exception flags
module fp16_normalize_round
    import fpu_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [4:0]       in_exp,
    input  logic [15:0]      in_mant,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_inexact,
    output logic             out_overflow,
    output logic             out_underflow
);

    logic s1_valid;
    logic s2_can_take;
    logic in_fire;

    assign s2_can_take = !out_valid || out_ready;
    assign in_ready    = !s1_valid || s2_can_take;
    assign in_fire     = in_valid && in_ready;

    // ---------------- Stage 1: normalize ----------------
    logic [4:0]        lz;
    logic [4:0]        exp_eff;
    logic signed [6:0] e;
    logic              norm_ok;
    logic [4:0]        shift;
    norm_stage_t       s1_next;
    norm_stage_t       s1;
    logic [TAG_W-1:0]  s1_tag;

    lzd_16 u_lzd (
        .mant  (in_mant),
        .count (lz)
    );

    always_comb begin
        exp_eff = (in_exp == 5'd0) ? 5'd1 : in_exp;
        e       = $signed({2'b00, exp_eff}) + 7'sd1 - $signed({2'b00, lz});
        norm_ok = (e >= 7'sd1);
        // A subnormal result only shifts far enough to put bit 15 at the
        // minimum-exponent weight; the rest of the leading zeros stay in mant.
        shift   = norm_ok ? lz : exp_eff;

        s1_next.sign  = in_sign;
        s1_next.exp_n = norm_ok ? e[4:0] : 5'd0;
        s1_next.mant  = in_mant << shift;
        s1_next.zero  = (in_mant == 16'd0);
        s1_next.ovf   = (e >= 7'sd31);
    end

    // ---------------- Stage 2: round and pack ----------------
    logic [FRAC_W-1:0] frac;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic              inexact;
    logic [14:0]       sum;
    fp16_t             res_next;
    logic              inexact_next;
    logic              overflow_next;
    logic              underflow_next;

    always_comb begin
        frac     = s1.mant[14:5];
        guard    = s1.mant[4];
        sticky   = |s1.mant[3:0];
        round_up = guard && (sticky || frac[0]);
        inexact  = guard || sticky;
        // Incrementing exponent and fraction together lets a fraction carry
        // bump the exponent (subnormal->normal, 1.111..->10.000).
        sum      = {s1.exp_n, frac} + {14'd0, round_up};

        res_next       = '0;
        res_next.sign  = s1.sign;
        inexact_next   = 1'b0;
        overflow_next  = 1'b0;
        underflow_next = 1'b0;

        if (s1.zero) begin
            res_next.sign = s1.sign;
        end else if (s1.ovf || (sum[14:10] == 5'(EXP_MAX))) begin
            res_next.exp  = 5'h1F;
            overflow_next = 1'b1;
            inexact_next  = 1'b1;
        end else begin
`ifdef FP_NORM_DENORM_EN
            res_next.exp   = sum[14:10];
            res_next.frac  = sum[9:0];
            inexact_next   = inexact;
            underflow_next = (s1.exp_n == 5'd0) && inexact;
`else
            if (sum[14:10] == 5'd0) begin
                underflow_next = 1'b1;
                inexact_next   = 1'b1;
            end else begin
                res_next.exp   = sum[14:10];
                res_next.frac  = sum[9:0];
                inexact_next   = inexact;
                underflow_next = (s1.exp_n == 5'd0) && inexact;
            end
`endif
        end
    end

    // ---------------- Pipeline registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1            <= '0;
            s1_tag        <= '0;
            out_valid     <= 1'b0;
            out_result    <= 16'd0;
            out_tag       <= '0;
            out_inexact   <= 1'b0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
        end else begin
            if (in_fire) begin
                s1     <= s1_next;
                s1_tag <= in_tag;
            end

            if (in_fire) begin
                s1_valid <= 1'b1;
            end else if (s2_can_take) begin
                s1_valid <= 1'b0;
            end

            if (s2_can_take) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_result    <= res_next;
                    out_tag       <= s1_tag;
                    out_inexact   <= inexact_next;
                    out_overflow  <= overflow_next;
                    out_underflow <= underflow_next;
                end
            end
        end
    end

endmodule
